seg7_capture_decoder: RTL

// Reader side of the 7-segment interface: samples a multiplexed segment bus
// (SEG + one-hot digit enable) and converts each settled pattern back to BCD.
// It assembles a DIGITS-wide frame and hands it off with a VALID/ACK handshake.

---
 rtl/seg7_capture_decoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/seg7_capture_decoder.sv
// ============================================================================
//  Module   : seg7_capture_decoder
//  Captures settled patterns from a multiplexed 7-segment bus, decodes them to
//  BCD and hands off DIGITS-wide frames through a VALID/ACK handshake.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_capture_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig_en,
    input  logic                  clr,
    input  logic                  ack,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     err,
    output logic                  valid,
    output logic                  overrun
);

    localparam int               C_SW      = 7 + DIGITS;
    // Capture fires when the count would reach STABLE_CYCLES-1 on this edge.
    localparam logic [CNT_W-1:0] C_CAP_CNT = CNT_W'(STABLE_CYCLES - 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    state_t              r_state, w_state_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic [C_SW-1:0]     r_sample;
    logic [C_SW-1:0]     w_in;
    logic                w_same, w_onehot, w_capture, w_commit;
    logic [DIGITS-1:0]   r_seen;
    logic [4*DIGITS-1:0] r_sh_bcd, r_bcd;
    logic [DIGITS-1:0]   r_sh_blank, r_sh_err, r_blank, r_err;
    logic                r_valid, r_overrun;
    logic [5:0]          w_dec;

    // Returns {blank, err, bcd[3:0]}.
    function automatic logic [5:0] f_decode(input logic [6:0] s);
        logic [5:0] v;
        case (s)
            7'h7E:   v = 6'h00;
            7'h30:   v = 6'h01;
            7'h6D:   v = 6'h02;
            7'h79:   v = 6'h03;
            7'h33:   v = 6'h04;
            7'h5B:   v = 6'h05;
            7'h1F:   v = 6'h06;
            7'h70:   v = 6'h07;
            7'h7F:   v = 6'h08;
            7'h7B:   v = 6'h09;
            7'h00:   v = {2'b10, 4'hF};
            default: v = {2'b01, 4'hE};
        endcase
        return v;
    endfunction

    always_comb begin
        w_in         = {seg, dig_en};
        w_same       = (w_in == r_sample);
        w_onehot     = $onehot(dig_en);
        w_dec        = f_decode(seg);
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_onehot) begin
                    w_state_next = ST_SETTLE;
                    w_cnt_next   = '0;
                end
            end
            ST_SETTLE: begin
                if (w_same) begin
                    if (r_cnt == C_CAP_CNT) begin
                        w_capture    = 1'b1;
                        w_state_next = ST_HELD;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_next   = '0;
                    w_state_next = w_onehot ? ST_SETTLE : ST_IDLE;
                end
            end
            ST_HELD: begin
                if (!w_same) begin
                    w_cnt_next   = '0;
                    w_state_next = w_onehot ? ST_SETTLE : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (clr) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
            w_capture    = 1'b0;
        end
        w_commit = (&r_seen) && !clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_sample <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_sample <= w_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen     <= '0;
            r_sh_bcd   <= '0;
            r_sh_blank <= '0;
            r_sh_err   <= '0;
            r_bcd      <= '0;
            r_blank    <= '0;
            r_err      <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (clr) begin
            r_seen    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            // A capture on the commit edge starts the next frame's seen mask.
            r_seen <= (w_commit ? '0 : r_seen) | (w_capture ? dig_en : '0);
            for (int i = 0; i < DIGITS; i++) begin
                if (w_capture && dig_en[i]) begin
                    r_sh_bcd[4*i +: 4] <= w_dec[3:0];
                    r_sh_blank[i]      <= w_dec[5];
                    r_sh_err[i]        <= w_dec[4];
                end
            end
            if (w_commit) begin
                r_bcd   <= r_sh_bcd;
                r_blank <= r_sh_blank;
                r_err   <= r_sh_err;
                r_valid <= 1'b1;
                if (r_valid && !ack)
                    r_overrun <= 1'b1;
            end else if (r_valid && ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bcd     = r_bcd;
    assign blank   = r_blank;
    assign err     = r_err;
    assign valid   = r_valid;
    assign overrun = r_overrun;

endmodule

`default_nettype wire
